// File: rtl/noc_input_port.sv
// noc_input_port: input stage of a mesh NoC router.
// Buffers flits in a DEPTH-entry FIFO, computes the XY route of the head flit
// at the FIFO front, holds a one-hot request for the whole packet and streams
// flits to the crossbar while the matching output arbiter grants.
// Optional build macro NOC_INPORT_DROP_ORPHAN_EN: body/tail flits that reach
// the front without a preceding head are discarded and flagged on err_orphan;
// without it such a flit blocks the port until rst.
module noc_input_port #(
    parameter int FLIT_W  = 18,
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 2,
    parameter int COORD_W = 2,
    parameter int CUR_X   = 0,
    parameter int CUR_Y   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] in_flit,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [4:0]        req,
    input  logic [4:0]        gnt,
    output logic [FLIT_W-1:0] out_flit,
    output logic              out_valid
`ifdef NOC_INPORT_DROP_ORPHAN_EN
    ,
    output logic              err_orphan
`endif
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

    logic [FLIT_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0]  rd_ptr, wr_ptr;
    logic [ADDR_W:0]    count;
    logic               full, empty, push, pop;
    logic [1:0]         ftype;
    logic               front_head, front_tail;
    logic [COORD_W-1:0] dx, dy;
    logic [4:0]         route, route_reg;
    logic               latch_route;
    state_t             state, state_nxt;
`ifdef NOC_INPORT_DROP_ORPHAN_EN
    logic               orphan;
`endif

    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    // in_ready is deliberately not raised by a same-cycle pop when full
    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;
    assign out_flit = mem[rd_ptr];

    // type bits: 10 head, 00 body, 01 tail, 11 single -> bit1 starts, bit0 ends
    assign ftype      = out_flit[FLIT_W-1:FLIT_W-2];
    assign front_head = ftype[1];
    assign front_tail = ftype[0];
    assign dx         = out_flit[2*COORD_W-1:COORD_W];
    assign dy         = out_flit[COORD_W-1:0];

    // XY routing: resolve X first, then Y, else eject locally (unsigned compares)
    always_comb begin
        route = 5'b00001;
        if (dx > COORD_W'(CUR_X))      route = 5'b00010;
        else if (dx < COORD_W'(CUR_X)) route = 5'b00100;
        else if (dy > COORD_W'(CUR_Y)) route = 5'b01000;
        else if (dy < COORD_W'(CUR_Y)) route = 5'b10000;
    end

    // packet FSM: request on head, stream while granted, release after tail
    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        out_valid   = 1'b0;
        req         = 5'b0;
        latch_route = 1'b0;
`ifdef NOC_INPORT_DROP_ORPHAN_EN
        orphan      = 1'b0;
`endif
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        if (front_head) begin
                            latch_route = 1'b1;
                            state_nxt   = BUSY;
                        end
`ifdef NOC_INPORT_DROP_ORPHAN_EN
                        else begin
                            pop    = 1'b1;
                            orphan = 1'b1;
                        end
`endif
                    end
                end
                BUSY: begin
                    req = route_reg;
                    // grant bits for other outputs are ignored
                    if (|(gnt & route_reg) && !empty) begin
                        pop       = 1'b1;
                        out_valid = 1'b1;
                        if (front_tail) state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

`ifdef NOC_INPORT_DROP_ORPHAN_EN
    assign err_orphan = orphan;
`endif

    // state and latched route; reset drops any packet in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            route_reg <= 5'b0;
        end else begin
            state <= state_nxt;
            if (latch_route) route_reg <= route;
        end
    end

    // FIFO pointers, occupancy and storage; reset flushes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_flit;
                wr_ptr      <= wr_ptr + ONE_A;
            end
            if (pop) rd_ptr <= rd_ptr + ONE_A;
            case ({push, pop})
                2'b10:   count <= count + ONE_C;
                2'b01:   count <= count - ONE_C;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_noc_input_port.sv
// tb_noc_input_port: directed + randomized checks of noc_input_port at
// CUR=(1,1), DEPTH=4, against a packet-level reference (flit queues and the
// XY rule evaluated on destination coordinates).
module tb_noc_input_port;
    localparam int FW = 18;
    localparam int CX = 1;
    localparam int CY = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [FW-1:0] in_flit = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [4:0]    req;
    logic [4:0]    gnt = 5'b0;
    logic [FW-1:0] out_flit;
    logic          out_valid;
`ifdef NOC_INPORT_DROP_ORPHAN_EN
    logic          err_orphan;
`endif

    int checks = 0;
    int errors = 0;
    int gmode  = 0;          // 0: grant echoes req, 1: forced, 2: random stall
    logic [4:0] gforce = 5'b0;

    logic [FW-1:0] outq[$];  // every transferred flit
    logic [4:0]    reqq[$];  // request value at each 0->nonzero rise
    logic [4:0]    req_d = 5'b0;

    noc_input_port #(.FLIT_W(FW), .DEPTH(4), .ADDR_W(2), .COORD_W(2),
                     .CUR_X(CX), .CUR_Y(CY)) dut (
        .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid),
        .in_ready(in_ready), .req(req), .gnt(gnt), .out_flit(out_flit),
        .out_valid(out_valid)
`ifdef NOC_INPORT_DROP_ORPHAN_EN
        , .err_orphan(err_orphan)
`endif
    );

    always #5 clk = ~clk;

    // output arbiter stand-in: registered grant, one cycle behind req
    always @(posedge clk) begin
        case (gmode)
            0:       gnt <= req;
            1:       gnt <= gforce;
            default: gnt <= ($urandom_range(0, 3) != 0) ? req : 5'b0;
        endcase
    end

    // transfer / request monitor
    always @(negedge clk) begin
        if (!rst && out_valid) outq.push_back(out_flit);
        if (!rst && req != 5'b0 && req_d == 5'b0) reqq.push_back(req);
        req_d <= rst ? 5'b0 : req;
    end

    task automatic drv(); @(posedge clk); #1; endtask
    task automatic smp(); @(negedge clk); #1; endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input int x, input int y);
        logic [11:0] pl;
        pl = 12'($urandom);
        return {t, pl, 2'(x), 2'(y)};
    endfunction

    // XY rule from the destination: X first, then Y, else local
    function automatic logic [4:0] exp_route(input int x, input int y);
        int dir;
        if (x > CX)      dir = 1;
        else if (x < CX) dir = 2;
        else if (y > CY) dir = 3;
        else if (y < CY) dir = 4;
        else             dir = 0;
        return 5'(1 << dir);
    endfunction

    localparam logic [1:0] HEAD = 2'b10, BODY = 2'b00, TAIL = 2'b01, SNGL = 2'b11;

    initial begin
        logic [FW-1:0] f1, s, w, p[4], q[5], r[4];
        logic [FW-1:0] sendq[$], expq[$];
        logic [4:0]    expr[$];
        int base, rbase, total, npk;

        // ---- reset state ----
        drv(); smp();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_req", req, 0);
        chk("rst_out_valid", out_valid, 0);
        drv(); rst = 1'b0; smp();
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_req", req, 0);

        // ---- single flit to (2,1): req at t+2, transfer at t+3, drop at t+4 ----
        f1 = mk(SNGL, 2, 1);
        for (int c = 0; c <= 4; c++) begin
            drv();
            in_valid = (c == 0);
            in_flit  = f1;
            smp();
            if (c == 1) chk("t1_req_t1", req, 0);
            if (c == 2) begin chk("t1_req_t2", req, exp_route(2, 1)); chk("t1_ov_t2", out_valid, 0); end
            if (c == 3) begin chk("t1_ov_t3", out_valid, 1); chk("t1_flit_t3", out_flit, f1); end
            if (c == 4) begin chk("t1_req_t4", req, 0); chk("t1_ov_t4", out_valid, 0); end
        end

        // ---- 4-flit packet to (1,0), then a single to (0,1) right behind ----
        p[0] = mk(HEAD, 1, 0); p[1] = mk(BODY, 3, 3); p[2] = mk(BODY, 0, 0); p[3] = mk(TAIL, 2, 2);
        s = mk(SNGL, 0, 1);
        for (int c = 0; c <= 10; c++) begin
            drv();
            in_valid = (c <= 4);
            in_flit  = (c <= 3) ? p[c] : s;
            smp();
            if (c == 2) chk("t2_req", req, exp_route(1, 0));
            if (c == 4) chk("t2_in_ready", in_ready, 1);
            if (c >= 3 && c <= 6) begin
                chk("t2_ov", out_valid, 1);
                chk("t2_flit", out_flit, p[c-3]);
            end
            if (c == 7) begin chk("t2_idle_req", req, 0); chk("t2_idle_ov", out_valid, 0); end
            if (c == 8) begin chk("t2_next_req", req, exp_route(0, 1)); chk("t2_next_ov", out_valid, 0); end
            if (c == 9) begin chk("t2_next_ov2", out_valid, 1); chk("t2_next_flit", out_flit, s); end
            if (c == 10) chk("t2_end_req", req, 0);
        end

        // ---- fill without grant: 5th flit refused, then drain in order ----
        q[0] = mk(HEAD, 3, 2); q[1] = mk(BODY, 1, 1); q[2] = mk(BODY, 2, 3); q[3] = mk(BODY, 0, 2);
        q[4] = mk(TAIL, 1, 3);
        gmode = 1; gforce = 5'b0;
        base = 0;
        for (int c = 0; c <= 5; c++) begin
            drv();
            in_valid = (c <= 4);
            in_flit  = q[(c <= 4) ? c : 4];
            if (c == 5) gmode = 0;
            smp();
            if (c <= 3) chk("t3_in_ready_open", in_ready, 1);
            else        chk("t3_in_ready_full", in_ready, 0);
            if (c == 5) begin chk("t3_req", req, exp_route(3, 2)); base = outq.size(); end
        end
        for (int c = 6; c <= 11; c++) begin drv(); in_valid = 1'b0; smp(); end
        chk("t3_drained", outq.size() - base, 4);
        for (int i = 0; i < 4 && base + i < outq.size(); i++) chk("t3_order", outq[base+i], q[i]);
        chk("t3_hold_req", req, exp_route(3, 2));
        chk("t3_hold_ov", out_valid, 0);
        for (int c = 12; c <= 15; c++) begin
            drv(); in_valid = (c == 12); in_flit = q[4]; smp();
        end
        chk("t3_tail_count", outq.size() - base, 5);
        if (outq.size() == base + 5) chk("t3_tail_flit", outq[base+4], q[4]);
        chk("t3_end_req", req, 0);

        // ---- wrong grant bit: nothing moves until the routed bit is granted ----
        w = mk(SNGL, 0, 1);
        gmode = 1; gforce = 5'b00001;
        for (int c = 0; c <= 8; c++) begin
            drv();
            in_valid = (c == 0);
            in_flit  = w;
            if (c == 6) gforce = 5'b00100;
            if (c == 7) gmode = 0;
            smp();
            if (c >= 3 && c <= 6) chk("t4_no_pop", out_valid, 0);
            if (c == 6) chk("t4_req", req, 5'b00100);
            if (c == 7) begin chk("t4_ov", out_valid, 1); chk("t4_flit", out_flit, w); end
            if (c == 8) chk("t4_end_req", req, 0);
        end

        // ---- reset mid-packet after two flits have left ----
        r[0] = mk(HEAD, 1, 2); r[1] = mk(BODY, 0, 0); r[2] = mk(BODY, 3, 3); r[3] = mk(TAIL, 1, 1);
        base = outq.size();
        for (int c = 0; c <= 10; c++) begin
            drv();
            in_valid = (c <= 3);
            in_flit  = r[(c <= 3) ? c : 3];
            rst      = (c == 5);
            smp();
            if (c == 2) chk("t5_req", req, 5'b01000);
            if (c == 5) begin
                chk("t5_rst_req", req, 0);
                chk("t5_rst_ov", out_valid, 0);
                chk("t5_rst_in_ready", in_ready, 0);
            end
            if (c == 6) begin
                chk("t5_after_req", req, 0);
                chk("t5_after_in_ready", in_ready, 1);
            end
        end
        chk("t5_popped_before_rst", outq.size() - base, 2);
        chk("t5_after_idle_req", req, 0);

`ifdef NOC_INPORT_DROP_ORPHAN_EN
        // ---- orphan body is dropped with a one-cycle err_orphan pulse ----
        p[0] = mk(BODY, 2, 2); p[1] = mk(HEAD, 0, 1); p[2] = mk(TAIL, 3, 0);
        base = outq.size();
        for (int c = 0; c <= 6; c++) begin
            drv();
            in_valid = (c <= 2);
            in_flit  = p[(c <= 2) ? c : 2];
            smp();
            chk("orph_err", err_orphan, (c == 1));
            if (c == 1) chk("orph_ov", out_valid, 0);
            if (c == 3) chk("orph_req", req, 5'b00100);
            if (c == 4) chk("orph_flit_head", out_flit, p[1]);
            if (c == 5) chk("orph_flit_tail", out_flit, p[2]);
            if (c == 6) chk("orph_end_req", req, 0);
        end
        chk("orph_count", outq.size() - base, 2);
`else
        // ---- orphan body blocks the port (and the head behind it) until rst ----
        p[0] = mk(BODY, 2, 2); p[1] = mk(SNGL, 2, 1);
        base = outq.size();
        for (int c = 0; c <= 7; c++) begin
            drv();
            in_valid = (c <= 1);
            in_flit  = p[(c <= 1) ? c : 1];
            rst      = (c == 7);
            smp();
            if (c >= 1 && c <= 6) chk("orph_block_req", req, 0);
        end
        chk("orph_block_count", outq.size() - base, 0);
        drv(); rst = 1'b0; smp();
        chk("orph_rst_in_ready", in_ready, 1);
`endif

        // ---- randomized packets with random input gaps and grant stalls ----
        npk = 25;
        for (int k = 0; k < npk; k++) begin
            int x, y, len;
            x = $urandom_range(0, 3); y = $urandom_range(0, 3); len = $urandom_range(1, 4);
            expr.push_back(exp_route(x, y));
            if (len == 1) begin
                sendq.push_back(mk(SNGL, x, y));
            end else begin
                sendq.push_back(mk(HEAD, x, y));
                for (int b = 0; b < len - 2; b++) sendq.push_back(mk(BODY, $urandom_range(0, 3), $urandom_range(0, 3)));
                sendq.push_back(mk(TAIL, $urandom_range(0, 3), $urandom_range(0, 3)));
            end
        end
        foreach (sendq[i]) expq.push_back(sendq[i]);
        total = expq.size();
        base  = outq.size();
        rbase = reqq.size();
        gmode = 2;
        for (int cyc = 0; cyc < 3000 && !(sendq.size() == 0 && outq.size() - base == total); cyc++) begin
            drv();
            if (sendq.size() != 0 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_flit  = sendq[0];
                if (in_ready) void'(sendq.pop_front());
            end else begin
                in_valid = 1'b0;
            end
            smp();
        end
        drv(); in_valid = 1'b0; gmode = 0; smp();
        drv(); smp();
        chk("rand_done", outq.size() - base, total);
        for (int i = 0; i < total && base + i < outq.size(); i++) chk("rand_flit", outq[base+i], expq[i]);
        chk("rand_req_count", reqq.size() - rbase, npk);
        for (int i = 0; i < npk && rbase + i < reqq.size(); i++) chk("rand_route", reqq[rbase+i], expr[i]);
        chk("rand_end_req", req, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
